// File: rtl/rv_pkg.sv
// Shared fetch-stage definitions: data width, canonical NOP encoding and the
// fetch FSM state type.
package rv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;
endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: synchronous imem read port plus the decode-facing
// valid/ready handshake. fetch_fault exists only with IFETCH_RANGE_CHECK_EN.
interface instr_fetch_if #(
  parameter int IMEM_AW = 10
);
  import rv_pkg::*;

  logic               imem_en;
  logic [IMEM_AW-1:0] imem_addr;
  logic [XLEN-1:0]    imem_rdata;
  logic [XLEN-1:0]    instr_out;
  logic [XLEN-1:0]    instr_pc;
  logic               instr_valid;
  logic               instr_ready;
`ifdef IFETCH_RANGE_CHECK_EN
  logic               fetch_fault;
`endif

  modport master (
    output imem_en, imem_addr,
    input  imem_rdata,
    output instr_out, instr_pc, instr_valid,
    input  instr_ready
`ifdef IFETCH_RANGE_CHECK_EN
    , output fetch_fault
`endif
  );

  modport slave (
    input  imem_en, imem_addr,
    output imem_rdata,
    input  instr_out, instr_pc, instr_valid,
    output instr_ready
`ifdef IFETCH_RANGE_CHECK_EN
    , input fetch_fault
`endif
  );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: samples pc_in, reads synchronous imem (MEM_LAT cycles), holds the
// word for decode. Optional out-of-range PC trap under IFETCH_RANGE_CHECK_EN.
module instr_fetch
  import rv_pkg::*;
#(
  parameter int IMEM_AW = 10,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  instr_fetch_if.master   bus
);

  localparam logic [1:0] LAT_LOAD = 2'(MEM_LAT - 1);

  fetch_state_t    r_state;
  fetch_state_t    w_state_next;
  logic            r_first;
  logic [1:0]      r_lat_cnt;
  logic [XLEN-1:0] r_req_pc;
  logic [XLEN-1:0] r_last_pc;
  logic [XLEN-1:0] r_instr_out;
  logic [XLEN-1:0] r_instr_pc;
  logic            r_valid;
  logic            w_imem_en;
  logic            w_capture;
  logic            w_handshake;
  logic            w_bad_pc;

`ifdef IFETCH_RANGE_CHECK_EN
  logic r_fault;
  assign w_bad_pc        = |pc_in[XLEN-1:IMEM_AW];
  assign bus.fetch_fault = r_fault;
`else
  assign w_bad_pc = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_imem_en    = 1'b0;
    w_capture    = 1'b0;
    w_handshake  = r_valid && bus.instr_ready;
    case (r_state)
      IDLE: if (r_first || (pc_in != r_last_pc)) w_state_next = REQ;
      REQ: begin
        if (w_bad_pc) begin
          w_state_next = HOLD;
        end else begin
          w_imem_en    = 1'b1;
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (r_lat_cnt == '0) begin
          w_capture    = 1'b1;
          w_state_next = HOLD;
        end
      end
      HOLD: if (w_handshake) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    // Flush overrides everything, including a same-cycle handshake or capture.
    if (flush) begin
      w_state_next = IDLE;
      w_imem_en    = 1'b0;
      w_capture    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_first     <= 1'b1;
      r_lat_cnt   <= '0;
      r_req_pc    <= '0;
      r_last_pc   <= '0;
      r_instr_out <= NOP_INSTR;
      r_instr_pc  <= '0;
      r_valid     <= 1'b0;
`ifdef IFETCH_RANGE_CHECK_EN
      r_fault     <= 1'b0;
`endif
    end else if (flush) begin
      r_first <= 1'b1;
      r_valid <= 1'b0;
`ifdef IFETCH_RANGE_CHECK_EN
      r_fault <= 1'b0;
`endif
    end else begin
      case (r_state)
        REQ: begin
          r_req_pc  <= pc_in;
          r_first   <= 1'b0;
          r_lat_cnt <= LAT_LOAD;
`ifdef IFETCH_RANGE_CHECK_EN
          if (w_bad_pc) begin
            r_instr_out <= NOP_INSTR;
            r_instr_pc  <= pc_in;
            r_last_pc   <= pc_in;
            r_valid     <= 1'b1;
            r_fault     <= 1'b1;
          end
`endif
        end
        WAIT: begin
          if (r_lat_cnt != '0) r_lat_cnt <= r_lat_cnt - 2'd1;
          if (w_capture) begin
            r_instr_out <= bus.imem_rdata;
            r_instr_pc  <= r_req_pc;
            r_last_pc   <= r_req_pc;
            r_valid     <= 1'b1;
          end
        end
        HOLD: begin
          if (w_handshake) begin
            r_valid <= 1'b0;
`ifdef IFETCH_RANGE_CHECK_EN
            r_fault <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_en     = w_imem_en;
  assign bus.imem_addr   = w_imem_en ? pc_in[IMEM_AW-1:0] : '0;
  assign bus.instr_out   = r_instr_out;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_valid;

endmodule
